// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial add controller.
package nsa_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Legal widths are whole nibbles, at least two of them.
    function automatic bit width_ok(input int unsigned w);
        return ((w % NIB_W) == 0) && (w >= 2 * NIB_W);
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice; also exposes the carry into its top bit.
module nibble_add_slice
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W:0]   full;
    logic [NIB_W-1:0] low;

    assign full = {1'b0, a} + {1'b0, b} + (NIB_W+1)'(cin);
    // Sum of the lower three bits; its MSB is the carry into bit 3.
    assign low  = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + NIB_W'(cin);

    assign s    = full[NIB_W-1:0];
    assign cout = full[NIB_W];
    assign c3   = low[NIB_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester round-robin controller that adds WIDTH-bit operands one
// nibble per cycle through a single shared slice and returns sum plus flags.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_cin,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_zero,
    output logic             resp_neg,
    output logic             resp_carry,
    output logic             resp_ovf,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d, neg_q, neg_d;
    logic             cflag_q, cflag_d, ovf_q, ovf_d;

    logic [1:0]       grant_c;
    logic             sel_c;
    logic [NIB_W-1:0] a_nib, b_nib, slice_s;
    logic             slice_cout, slice_c3;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        grant_c = 2'b00;
        case (req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant_c : 2'b00;

    // Operand nibble selected by the running counter.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_add_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            cflag_q <= cflag_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        cflag_d = cflag_q;
        ovf_d   = ovf_q;
        sel_c   = req_ready[1];

        case (state_q)
            ST_IDLE: begin
                if (|(req_valid & req_ready)) begin
                    a_d     = sel_c ? req_a1 : req_a0;
                    b_d     = sel_c ? req_b1 : req_b0;
                    carry_d = req_cin[sel_c];
                    id_d    = sel_c;
                    last_d  = sel_c;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i*NIB_W +: NIB_W] = slice_s;
                    end
                end
                carry_d = slice_cout;
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    // Flags are taken from the final nibble as DONE is entered.
                    zero_d  = (sum_d == '0);
                    neg_d   = sum_d[WIDTH-1];
                    cflag_d = slice_cout;
                    ovf_d   = slice_c3 ^ slice_cout;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_zero  = zero_q;
    assign resp_neg   = neg_q;
    assign resp_carry = cflag_q;
    assign resp_ovf   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: acceptances push whole-word arithmetic predictions,
// a response monitor pops and compares them.
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   req_cin;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_zero, resp_neg, resp_carry, resp_ovf, busy;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_zero  (resp_zero),
        .resp_neg   (resp_neg),
        .resp_carry (resp_carry),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         z, n, c, v;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic last_m = 1'b1;
    logic prev_valid = 1'b0;
    logic directed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Whole-word two's-complement reference.
    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input int acc);
        exp_t       e;
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        e.id  = id;
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.z   = (e.sum == '0);
        e.n   = e.sum[W-1];
        e.v   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.acc = acc;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (!directed) resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Acceptance monitor: predict the grant, push the expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_m = 1'b1;
        end else if (|(req_valid & req_ready)) begin
            logic m;
            m = (req_valid == 2'b11) ? ~last_m : req_valid[1];
            chk("grant", 32'(req_ready), m ? 32'd2 : 32'd1);
            q.push_back(model(m, m ? req_a1 : req_a0, m ? req_b1 : req_b0, req_cin[m], cyc + 1));
            last_m = m;
        end
    end

    // Response monitor: compare every cycle the response is presented.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got sum 0x%0h required no response", resp_sum);
            end else begin
                if (!prev_valid) chk("latency", 32'(cyc), 32'(q[0].acc + LAT));
                chk("resp_id", 32'(resp_id), 32'(q[0].id));
                chk("resp_sum", 32'(resp_sum), 32'(q[0].sum));
                chk("resp_flags", {28'd0, resp_zero, resp_neg, resp_carry, resp_ovf},
                    {28'd0, q[0].z, q[0].n, q[0].c, q[0].v});
                if (resp_ready) void'(q.pop_front());
            end
        end
        if (rst_n && busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
        prev_valid = resp_valid;
    end

    task automatic wait_accept(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                g = req_valid & req_ready;
                return;
            end
        end
        checks++;
        $display("FAIL accept_timeout: got no acceptance required one within 300 cycles");
    endtask

    task automatic scramble();
        req_a0 = W'($urandom); req_b0 = W'($urandom);
        req_a1 = W'($urandom); req_b1 = W'($urandom);
        req_cin = 2'($urandom);
    endtask

    task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [1:0] g;
        @(posedge clk); #1;
        if (who == 0) begin req_a0 = a; req_b0 = b; end
        else          begin req_a1 = a; req_b1 = b; end
        req_cin[who]   = cin;
        req_valid[who] = 1'b1;
        wait_accept(g);
        @(posedge clk); #1;
        req_valid = 2'b00;
        scramble();
    endtask

    task automatic issue_both();
        logic [1:0] g;
        @(posedge clk); #1;
        scramble();
        req_valid = 2'b11;
        for (int n = 0; n < 2; n++) begin
            wait_accept(g);
            @(posedge clk); #1;
            req_valid = req_valid & ~g;
            scramble();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        checks++;
        $display("FAIL drain_timeout: got %0d pending required 0", q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b0; scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outputs", {22'd0, resp_valid, busy, resp_id, resp_zero, resp_neg, resp_carry, resp_ovf, 3'd0},
            32'd0);
        chk("rst_sum", 32'(resp_sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both held valid from reset: grants must alternate 0,1,0.
        for (int n = 0; n < 3; n++) begin
            wait_accept(g);
            chk("alt_grant", 32'(g), (n == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            scramble();
        end
        req_valid = 2'b00;
        drain();

        issue(0, 16'h7FFF, 16'h0001, 1'b0);
        issue(1, 16'hFFFF, 16'h0001, 1'b0);
        issue(0, 16'h1234, 16'h0FFF, 1'b1);
        drain();

        // Consumer stalls three cycles in DONE.
        @(posedge clk); #1;
        directed = 1'b1; resp_ready = 1'b0;
        issue(1, 16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        chk("stall_valid", 32'(resp_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_hs", {30'd0, busy, resp_valid}, 32'd0);
        directed = 1'b0;
        drain();

        // Reset while cnt=2 aborts the operation silently.
        issue(0, 16'h0F0F, 16'h0101, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {25'd0, resp_valid, busy, resp_id, resp_zero, resp_neg, resp_carry, resp_ovf},
            32'd0);
        chk("abort_sum", 32'(resp_sum), 32'd0);
        issue(1, 16'h1234, 16'h0FFF, 1'b1);
        drain();

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) issue_both();
            else issue(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom));
        end
        issue(0, 16'h0000, 16'h0000, 1'b0);
        issue(1, 16'h8000, 16'hFFFF, 1'b1);
        drain();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
